// File: rtl/cond_exec_unit.sv
// Conditional-execution unit: grouped status flags, ARM condition evaluation,
// registered condition result gating the write enables, and an IT-block sequencer.
module cond_exec_unit #(
  parameter int NFLAGS  = 4,
  parameter int NGROUPS = 2,
  parameter int ITDEPTH = 4,
  localparam int LENW   = $clog2(ITDEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          Cond,
  input  logic [NFLAGS-1:0]   ALUFlags,
  input  logic [NGROUPS-1:0]  FlagW,
  input  logic                ExecStrobe,
  input  logic                InstrDone,
  input  logic                PCS,
  input  logic                NextPC,
  input  logic                RegW,
  input  logic                MemW,
  input  logic                noRegW,
  input  logic                ITStart,
  input  logic [3:0]          ITCond,
  input  logic [LENW-1:0]     ITLen,
  input  logic [ITDEPTH-1:0]  ITMask,
  output logic                PCWrite,
  output logic                RegWrite,
  output logic                MemWrite,
  output logic [NFLAGS-1:0]   Flags,
  output logic                CondExQ,
  output logic                ITActive
);

  localparam int GW = NFLAGS / NGROUPS;
  localparam logic [LENW-1:0] ITDEPTH_L = LENW'(ITDEPTH);
  localparam logic [LENW-1:0] ONE_L     = LENW'(1);

  typedef enum logic {
    IT_IDLE   = 1'b0,
    IT_ACTIVE = 1'b1
  } it_state_t;

  it_state_t          state_reg, state_next;
  logic [3:0]         itcond_reg, itcond_next;
  logic [LENW-1:0]    count_reg, count_next;
  logic [ITDEPTH-1:0] mask_reg, mask_next;
  logic               cond_exq_reg;
  logic [NFLAGS-1:0]  flags_all;
  logic [3:0]         eff_cond;
  logic               cond_ex;
  logic               it_start_ok;
  logic               flag_n, flag_z, flag_c, flag_v;

  // Inside an IT block the low mask bit picks the base condition or its inverse.
  always_comb begin
    eff_cond = Cond;
    if (state_reg == IT_ACTIVE) begin
      eff_cond = mask_reg[0] ? itcond_reg : (itcond_reg ^ 4'b0001);
    end
  end

  assign flag_n = flags_all[NFLAGS-1];
  assign flag_z = flags_all[NFLAGS-2];
  assign flag_c = flags_all[NFLAGS-3];
  assign flag_v = flags_all[NFLAGS-4];

  always_comb begin
    cond_ex = 1'b0;
    case (eff_cond)
      4'b0000: cond_ex = flag_z;
      4'b0001: cond_ex = ~flag_z;
      4'b0010: cond_ex = flag_c;
      4'b0011: cond_ex = ~flag_c;
      4'b0100: cond_ex = flag_n;
      4'b0101: cond_ex = ~flag_n;
      4'b0110: cond_ex = flag_v;
      4'b0111: cond_ex = ~flag_v;
      4'b1000: cond_ex = flag_c & ~flag_z;
      4'b1001: cond_ex = ~flag_c | flag_z;
      4'b1010: cond_ex = (flag_n == flag_v);
      4'b1011: cond_ex = (flag_n != flag_v);
      4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_ex = flag_z | (flag_n != flag_v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Each group is written only by a passing instruction that requests it.
  genvar gi;
  generate
    for (gi = 0; gi < NGROUPS; gi++) begin : g_flag_grp
      logic [GW-1:0] grp_reg;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          grp_reg <= '0;
        end else if (ExecStrobe & FlagW[gi] & cond_ex) begin
          grp_reg <= ALUFlags[gi*GW +: GW];
        end
      end

      assign flags_all[gi*GW +: GW] = grp_reg;
    end
  endgenerate

  assign Flags = flags_all;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cond_exq_reg <= 1'b0;
    end else if (ExecStrobe) begin
      cond_exq_reg <= cond_ex;
    end
  end

  assign it_start_ok = ExecStrobe & ITStart & (ITLen != '0) & (ITLen <= ITDEPTH_L);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IT_IDLE;
      itcond_reg <= '0;
      count_reg  <= '0;
      mask_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      itcond_reg <= itcond_next;
      count_reg  <= count_next;
      mask_reg   <= mask_next;
    end
  end

  // A retire coinciding with the IT start belongs to the IT instruction itself.
  always_comb begin
    state_next  = state_reg;
    itcond_next = itcond_reg;
    count_next  = count_reg;
    mask_next   = mask_reg;
    case (state_reg)
      IT_IDLE: begin
        if (it_start_ok) begin
          state_next  = IT_ACTIVE;
          itcond_next = ITCond;
          count_next  = ITLen;
          mask_next   = ITMask;
        end
      end
      IT_ACTIVE: begin
        if (InstrDone) begin
          count_next = count_reg - ONE_L;
          mask_next  = mask_reg >> 1;
          if (count_reg == ONE_L) begin
            state_next = IT_IDLE;
          end
        end
      end
      default: state_next = IT_IDLE;
    endcase
  end

  always_comb begin
    ITActive = (state_reg == IT_ACTIVE);
    CondExQ  = cond_exq_reg;
    RegWrite = RegW & cond_exq_reg & ~noRegW;
    MemWrite = MemW & cond_exq_reg;
    PCWrite  = (PCS & cond_exq_reg) | NextPC;
  end

endmodule
